// File: rtl/pipeline_mem_wb_skid.sv
// MEM/WB pipeline register with a 2-entry skid buffer, flush and x0-write suppression.
// Define PMW_STALL_CNT_EN to add the saturating stall_cnt back-pressure counter port.
module pipeline_mem_wb_skid #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_data,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic [XLEN-1:0]   in_sign_imm,
    input  logic              in_reg_write,
    input  logic [1:0]        in_mem2reg,
    input  logic [REG_AW-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [XLEN-1:0]   out_alu_res,
    output logic [XLEN-1:0]   out_sign_imm,
    output logic              out_reg_write,
    output logic [1:0]        out_mem2reg,
    output logic [REG_AW-1:0] out_rd
`ifdef PMW_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   alu_res;
        logic [XLEN-1:0]   sign_imm;
        logic              reg_write;
        logic [1:0]        mem2reg;
        logic [REG_AW-1:0] rd;
    } ent_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    ent_t   main_q;
    ent_t   skid_q;
    ent_t   in_ent;
    logic   valid_q;
    logic   rdy_q;
    logic   accept;
    logic   consume;

    // Writes to x0 are dropped at capture so downstream never sees them.
    assign in_ent = '{
        data:      in_data,
        alu_res:   in_alu_res,
        sign_imm:  in_sign_imm,
        reg_write: in_reg_write && (in_rd != '0),
        mem2reg:   in_mem2reg,
        rd:        in_rd
    };

    assign accept  = in_valid && rdy_q;
    assign consume = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else if (flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    rdy_q <= 1'b1;
                    if (accept) begin
                        main_q  <= in_ent;
                        valid_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_q <= in_ent;
                    end else if (accept) begin
                        skid_q <= in_ent;
                        rdy_q  <= 1'b0;
                        state  <= TWO;
                    end else if (consume) begin
                        valid_q <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        main_q <= skid_q;
                        rdy_q  <= 1'b1;
                        state  <= ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    rdy_q   <= 1'b1;
                    state   <= EMPTY;
                end
            endcase
        end
`ifdef PMW_STALL_CNT_EN
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!flush && valid_q && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
`endif
    end

    assign in_ready      = rdy_q;
    assign out_valid     = valid_q;
    assign out_data      = main_q.data;
    assign out_alu_res   = main_q.alu_res;
    assign out_sign_imm  = main_q.sign_imm;
    assign out_reg_write = valid_q && main_q.reg_write;
    assign out_mem2reg   = main_q.mem2reg;
    assign out_rd        = main_q.rd;

endmodule

// File: tb/tb_pipeline_mem_wb_skid.sv
// Randomised self-checking bench for pipeline_mem_wb_skid against a queue model.
// Stall counter checks are compiled in with PMW_STALL_CNT_EN.
module tb_pipeline_mem_wb_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_alu_res;
    logic [31:0] in_sign_imm;
    logic        in_reg_write;
    logic [1:0]  in_mem2reg;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_alu_res;
    logic [31:0] out_sign_imm;
    logic        out_reg_write;
    logic [1:0]  out_mem2reg;
    logic [4:0]  out_rd;
`ifdef PMW_STALL_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_mem_wb_skid #(
        .XLEN(32),
        .REG_AW(5),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_alu_res(in_alu_res),
        .in_sign_imm(in_sign_imm),
        .in_reg_write(in_reg_write),
        .in_mem2reg(in_mem2reg),
        .in_rd(in_rd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_alu_res(out_alu_res),
        .out_sign_imm(out_sign_imm),
        .out_reg_write(out_reg_write),
        .out_mem2reg(out_mem2reg),
        .out_rd(out_rd)
`ifdef PMW_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] alu;
        logic [31:0] imm;
        logic        rw;
        logic [1:0]  m2r;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    ent_t held;
    logic m_rdy;
    int   m_cnt;

    wire [105:0] act_vec = {in_ready, out_valid, out_reg_write, out_mem2reg,
                            out_rd, out_data, out_alu_res, out_sign_imm};

    // Reference: the stage is a FIFO of capacity two.
    task automatic model_edge();
        ent_t e;
        bit   acc;
        bit   con;
        if (!rst) begin
            q.delete();
            held  = '0;
            m_rdy = 1'b0;
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
            m_rdy = 1'b1;
        end else begin
            acc = in_valid && m_rdy;
            con = (q.size() > 0) && out_ready;
            if (q.size() > 0 && !out_ready && m_cnt < 15) m_cnt++;
            if (con) void'(q.pop_front());
            if (acc) begin
                e = '{in_data, in_alu_res, in_sign_imm,
                      in_reg_write && (in_rd != 0), in_mem2reg, in_rd};
                q.push_back(e);
            end
            m_rdy = q.size() < 2;
        end
        if (q.size() > 0) held = q[0];
    endtask

    function automatic logic [105:0] exp_vec();
        logic v;
        v = q.size() > 0;
        return {m_rdy, v, v && held.rw, held.m2r, held.rd,
                held.data, held.alu, held.imm};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_fields();
        in_data      = $urandom;
        in_alu_res   = $urandom;
        in_sign_imm  = $urandom;
        in_reg_write = 1'($urandom_range(0, 1));
        in_mem2reg   = 2'($urandom_range(0, 3));
        in_rd        = 5'($urandom_range(0, 31));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        rand_fields();
        repeat (3) begin
            cycle();
            total++;
            if (act_vec !== '0) begin
                bad++;
                $display("FAIL reset_zero got=%h want=0", act_vec);
            end
        end
        rst = 1'b1;
        cycle();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release rdy=%b vld=%b want rdy=1 vld=0",
                     in_ready, out_valid);
        end
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_data !== in_data) begin
            bad++;
            $display("FAIL reset_first got vld=%b d=%h want vld=1 d=%h",
                     out_valid, out_data, in_data);
        end
        total++;
        if (act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL reset_model got=%h want=%h", act_vec, exp_vec());
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        drain();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            in_valid   = 1'b1;
            in_alu_res = 32'h10 + 32'(i);
            cycle();
            total++;
            if (out_valid !== 1'b1 || out_alu_res !== 32'h10 + 32'(i)) begin
                bad++;
                $display("FAIL stream_%0d got vld=%b alu=%h want vld=1 alu=%h",
                         i, out_valid, out_alu_res, 32'h10 + 32'(i));
            end
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL stream_model got=%h want=%h", act_vec, exp_vec());
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_ab();
        out_ready = 1'b0;
        rand_fields();
        in_valid = 1'b1;
        in_data  = 32'hAAAA0001;
        cycle();
        rand_fields();
        in_data = 32'hBBBB0002;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_skid();
        drain();
        fill_ab();
        repeat (2) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_data !== 32'hAAAA0001) begin
                bad++;
                $display("FAIL skid_full rdy=%b vld=%b d=%h want rdy=0 vld=1 d=aaaa0001",
                         in_ready, out_valid, out_data);
            end
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hBBBB0002 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL skid_a_out vld=%b d=%h rdy=%b want vld=1 d=bbbb0002 rdy=1",
                     out_valid, out_data, in_ready);
        end
        cycle();
        total++;
        if (out_valid !== 1'b0 || act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL skid_b_out got=%h want=%h", act_vec, exp_vec());
        end
    endtask

    task automatic test_flush();
        drain();
        fill_ab();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h5;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_two vld=%b rw=%b rdy=%b want 0 0 1",
                     out_valid, out_reg_write, in_ready);
        end
        out_ready = 1'b0;
        rand_fields();
        in_valid = 1'b1;
        cycle();
        flush   = 1'b1;
        in_data = 32'h5;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_one vld=%b rdy=%b want vld=0 rdy=1",
                     out_valid, in_ready);
        end
        repeat (3) cycle();
        total++;
        if (out_valid !== 1'b0 || act_vec !== exp_vec()) begin
            bad++;
            $display("FAIL flush_no5 got=%h want=%h", act_vec, exp_vec());
        end
    endtask

    task automatic test_x0();
        drain();
        rand_fields();
        in_valid     = 1'b1;
        in_rd        = 5'd0;
        in_reg_write = 1'b1;
        cycle();
        total++;
        if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || out_rd !== 5'd0) begin
            bad++;
            $display("FAIL x0_drop vld=%b rw=%b rd=%0d want vld=1 rw=0 rd=0",
                     out_valid, out_reg_write, out_rd);
        end
        in_rd = 5'd7;
        cycle();
        total++;
        if (out_reg_write !== 1'b1 || out_rd !== 5'd7) begin
            bad++;
            $display("FAIL x7_keep rw=%b rd=%0d want rw=1 rd=7",
                     out_reg_write, out_rd);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rand_fields();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 24) == 0;
            rst       = $urandom_range(0, 59) != 0;
            cycle();
            total++;
            if (act_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random_%0d got=%h want=%h", i, act_vec, exp_vec());
            end
        end
        rst   = 1'b1;
        flush = 1'b0;
    endtask

`ifdef PMW_STALL_CNT_EN
    task automatic test_stall();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        rst       = 1'b1;
        out_ready = 1'b0;
        rand_fields();
        in_valid = 1'b1;
        repeat (2) cycle();
        in_valid = 1'b0;
        repeat (20) cycle();
        total++;
        if (stall_cnt !== 4'd15 || stall_cnt !== 4'(m_cnt)) begin
            bad++;
            $display("FAIL stall_sat got=%0d want=15", stall_cnt);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        total++;
        if (stall_cnt !== 4'd15) begin
            bad++;
            $display("FAIL stall_flush got=%0d want=15", stall_cnt);
        end
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        total++;
        if (stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL stall_reset got=%0d want=0", stall_cnt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rand_fields();
        m_rdy = 1'b0;
        m_cnt = 0;
        held  = '0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_x0();
        test_random();
`ifdef PMW_STALL_CNT_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
